// File: rtl/cla_pkg.sv
// Shared types and parameter-legality helpers for the pipelined lookahead adder.
// The PIPE_CLA_SUB_EN build option (subtract mode) is handled in pipe_cla_adder.
package cla_pkg;

    // Upper bound on WIDTH; stage records are sized to it so the type can live here.
    localparam int unsigned MaxWidth = 128;

    typedef struct packed {
        logic                valid;
        logic                sub;
        logic                carry;
        logic [MaxWidth-1:0] sum;
        logic [MaxWidth-1:0] a;
        logic [MaxWidth-1:0] b;
    } stage_t;

    function automatic bit cla_params_ok(input int unsigned width,
                                         input int unsigned segs,
                                         input int unsigned group);
        return (segs > 0) && (group > 0) && (width > 0) && (width <= MaxWidth) &&
               ((width % (segs * group)) == 0);
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational W-bit two-level group carry-lookahead adder (GROUP-bit groups).
// Every carry is a flat sum of products; nothing ripples from group to group.
module cla_seg #(
    parameter int unsigned W     = 4,
    parameter int unsigned GROUP = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    localparam int unsigned NG = W / GROUP;

    logic [W-1:0]  w_g;
    logic [W-1:0]  w_p;
    logic [W-1:0]  w_c;
    logic [NG-1:0] w_gg;
    logic [NG-1:0] w_gp;
    logic [NG:0]   w_gc;
    logic          w_term;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_gg   = '0;
        w_gp   = '1;
        w_gc   = '0;
        w_c    = '0;
        w_term = 1'b0;

        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                w_gg[j] = w_g[j*GROUP+i] | (w_p[j*GROUP+i] & w_gg[j]);
                w_gp[j] = w_gp[j] & w_p[j*GROUP+i];
            end
        end

        // Second level: carry into group j expanded over all lower groups and cin.
        for (int j = 0; j <= NG; j++) begin
            w_term = i_cin;
            for (int m = 0; m < j; m++) w_term = w_term & w_gp[m];
            w_gc[j] = w_term;
            for (int i = 0; i < j; i++) begin
                w_term = w_gg[i];
                for (int m = i + 1; m < j; m++) w_term = w_term & w_gp[m];
                w_gc[j] = w_gc[j] | w_term;
            end
        end

        // First level: bit carries inside each group from that group's carry-in.
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                w_term = w_gc[j];
                for (int m = 0; m < i; m++) w_term = w_term & w_p[j*GROUP+m];
                w_c[j*GROUP+i] = w_term;
                for (int n = 0; n < i; n++) begin
                    w_term = w_g[j*GROUP+n];
                    for (int m = n + 1; m < i; m++) w_term = w_term & w_p[j*GROUP+m];
                    w_c[j*GROUP+i] = w_c[j*GROUP+i] | w_term;
                end
            end
        end
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[NG];

endmodule

// File: rtl/pipe_cla_adder.sv
// SEGS-stage pipelined adder; stage k adds slice k and passes its carry on.
// Define PIPE_CLA_SUB_EN to add the sub port (a + ~b + 1 when sub = 1).
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEGS  = 4,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned SegW = WIDTH / SEGS;

    if (!cla_params_ok(WIDTH, SEGS, GROUP)) begin : g_bad_params
        $error("pipe_cla_adder: WIDTH must be a multiple of SEGS*GROUP and <= MaxWidth");
    end

    logic   w_advance;
    logic   w_sub;
    stage_t w_entry;
    stage_t w_last;
    stage_t w_stage_q [SEGS];

`ifdef PIPE_CLA_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Global stall: every stage moves together or not at all.
    assign w_advance = !w_last.valid || out_ready;
    assign in_ready  = w_advance && !rst;

    always_comb begin
        w_entry              = '0;
        w_entry.valid        = in_valid;
        w_entry.sub          = w_sub;
        w_entry.carry        = w_sub ? 1'b1 : cin;
        w_entry.a[WIDTH-1:0] = a;
        w_entry.b[WIDTH-1:0] = b;
    end

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        stage_t            w_in;
        stage_t            w_next;
        stage_t            r_stage;
        logic [SegW-1:0]   w_slice_sum;
        logic              w_slice_cout;

        if (k == 0) begin : g_first
            assign w_in = w_entry;
        end else begin : g_rest
            assign w_in = w_stage_q[k-1];
        end

        cla_seg #(
            .W     (SegW),
            .GROUP (GROUP)
        ) u_seg (
            .i_a    (w_in.a[k*SegW +: SegW]),
            .i_b    (w_in.b[k*SegW +: SegW] ^ {SegW{w_in.sub}}),
            .i_cin  (w_in.carry),
            .o_sum  (w_slice_sum),
            .o_cout (w_slice_cout)
        );

        // Bubbles are flushed to all-zero so idle outputs read as zero.
        always_comb begin
            w_next = '0;
            if (w_in.valid) begin
                w_next                      = w_in;
                w_next.sum[k*SegW +: SegW]  = w_slice_sum;
                w_next.carry                = w_slice_cout;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_stage <= '0;
            end else if (w_advance) begin
                r_stage <= w_next;
            end
        end

        assign w_stage_q[k] = r_stage;
    end

    assign w_last    = w_stage_q[SEGS-1];
    assign out_valid = w_last.valid;
    assign sum       = w_last.sum[WIDTH-1:0];
    assign cout      = w_last.carry;
    assign overflow  = (w_last.a[WIDTH-1] == (w_last.b[WIDTH-1] ^ w_last.sub)) &&
                       (w_last.sum[WIDTH-1] != w_last.a[WIDTH-1]);

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (WIDTH=16, SEGS=4, GROUP=4).
// Sub-mode checks are compiled in when PIPE_CLA_SUB_EN is defined.
module tb_pipe_cla_adder;

    localparam int W = 16;
`ifdef PIPE_CLA_SUB_EN
    localparam bit HasSub = 1'b1;
`else
    localparam bit HasSub = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t        vecs [8];
    logic [17:0] exp_q [$];
    logic [17:0] bb_exp [8];
    logic [17:0] st_exp [4];
    logic [17:0] prev_out;
    logic        held;

    pipe_cla_adder #(
        .WIDTH (16),
        .SEGS  (4),
        .GROUP (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPE_CLA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    // Reference: plain integer arithmetic, signed overflow from the true signed result.
    function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                              input logic ci, input logic sb);
        logic [15:0] yy;
        logic        c;
        int          us;
        int          ss;
        logic        ovf;
        yy  = sb ? ~y : y;
        c   = sb ? 1'b1 : ci;
        us  = int'(x) + int'(yy) + int'(c);
        ss  = int'($signed(x)) + int'($signed(yy)) + int'(c);
        ovf = (ss > 32767) || (ss < -32768);
        return {ovf, us[16], us[15:0]};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b, want %0b", name, act, exp);
    endtask

    task automatic check_word(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %05h, want %05h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string name);
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            check_bit({name, "_unexpected"}, out_valid, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check_word(name, {overflow, cout, sum}, e);
        end
    endtask

    task automatic rand_ops();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; held = 1'b0; prev_out = '0;

        // Reset state
        tick(); tick();
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_word("rst_outputs", {overflow, cout, sum}, 18'h0);
        check_bit("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check_bit("post_rst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();

        // Single vectors: result exactly 4 cycles after acceptance
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
            #1;
            check_bit("vec_in_ready", in_ready, 1'b1);
            tick();
            in_valid = 1'b0;
            for (int c = 1; c < 4; c++) begin
                check_bit("vec_early", out_valid, 1'b0);
                tick();
            end
            check_bit("vec_valid", out_valid, 1'b1);
            check_word("vec_result", {overflow, cout, sum}, {vecs[i].ov, vecs[i].co, vecs[i].s});
            tick();
        end

        // Back-to-back: 8 accepts, 8 consecutive results starting at cycle 4
        for (int t = 0; t < 13; t++) begin
            if (t >= 4 && t < 12) begin
                check_bit("b2b_valid", out_valid, 1'b1);
                check_word("b2b_result", {overflow, cout, sum}, bb_exp[t-4]);
            end else begin
                check_bit("b2b_idle", out_valid, 1'b0);
            end
            if (t < 8) begin
                in_valid = 1'b1;
                rand_ops();
                bb_exp[t] = ref_model(a, b, cin, 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t < 8) check_bit("b2b_in_ready", in_ready, 1'b1);
            tick();
        end

        // Stall with a full pipe: outputs held, offered operands not captured
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1;
            rand_ops();
            st_exp[t] = ref_model(a, b, cin, 1'b0);
            tick();
        end
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            in_valid = 1'b1;
            rand_ops();
            #1;
            check_bit("stall_in_ready", in_ready, 1'b0);
            check_bit("stall_valid", out_valid, 1'b1);
            check_word("stall_hold", {overflow, cout, sum}, st_exp[0]);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_bit("release_valid", out_valid, 1'b1);
            check_word("release_result", {overflow, cout, sum}, st_exp[i]);
            tick();
        end
        #1;
        check_bit("release_no_dup", out_valid, 1'b0);
        tick();

        // Reset with 3 transactions in flight
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_bit("midrst_in_ready", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_bit("midrst_flush", out_valid, 1'b0);
            if (i == 0) check_bit("midrst_ready_after", in_ready, 1'b1);
            tick();
        end

        // Accept on the first cycle after reset release
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        #1;
        check_bit("first_cycle_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check_bit("first_cycle_valid", out_valid, 1'b1);
        check_word("first_cycle_result", {overflow, cout, sum}, 18'h03333);
        tick();

`ifdef PIPE_CLA_SUB_EN
        // 5 - 7 with cin ignored
        in_valid = 1'b1; sub = 1'b1; a = 16'h0005; b = 16'h0007; cin = 1'b0;
        tick();
        in_valid = 1'b0; sub = 1'b0;
        tick(); tick(); tick();
        check_bit("sub_valid", out_valid, 1'b1);
        check_word("sub_result", {overflow, cout, sum}, 18'h0FFFE);
        tick();
`endif

        // Randomised traffic against the reference model
        for (int t = 0; t < 300; t++) begin
            if (held) check_word("hold_stable", {overflow, cout, sum}, prev_out);
            in_valid  = ($urandom_range(0, 3) != 0);
            rand_ops();
            sub       = HasSub ? 1'($urandom) : 1'b0;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            check_bit("in_ready_rule", in_ready, !out_valid || out_ready);
            if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, cin, sub));
            if (out_valid && out_ready) pop_check("rand_result");
            held     = out_valid && !out_ready;
            prev_out = {overflow, cout, sum};
            tick();
        end
        in_valid  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
            #1;
            if (out_valid) pop_check("drain_result");
            tick();
        end
        check_word("drain_empty", 18'(exp_q.size()), 18'h0);
        #1;
        check_bit("drain_idle", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
